// File: rtl/game_flow_ctrl_pkg.sv
// Shared encodings for the game flow controller: FSM states, World status codes, widths.
// Pure definitions; no timing or flow control of its own.
package game_flow_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_TITLE    = 3'd0,
    ST_START    = 3'd1,
    ST_FADE_IN  = 3'd2,
    ST_PLAY     = 3'd3,
    ST_HOLD     = 3'd4,
    ST_FADE_OUT = 3'd5,
    ST_GAMEOVER = 3'd6,
    ST_WON      = 3'd7
  } state_t;

  localparam logic [1:0] OVER_PLAY = 2'd0;
  localparam logic [1:0] OVER_DIED = 2'd1;
  localparam logic [1:0] OVER_WON  = 2'd2;

  localparam int MASK_W  = 12;
  localparam int LVL_W   = 4;
  localparam int LIVES_W = 4;
  localparam int CNT_W   = 16;

  localparam logic [LVL_W-1:0] LVL_MAX = 4'hF;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_edge_detect.sv
// Rising-edge detector with one clk of history; history resets high so a level held through reset is not an edge.
// Latency: combinational pulse in the cycle the input first reads high; no backpressure.
module edge_detect (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) din_q <= 1'b1;
    else       din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow FSM: title, world restart, fade in/out of the brightness mask, lives and end screens.
// Latency: outputs registered, one clk after the deciding input; no backpressure, frame_tick paces all timing.
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int LIVES       = 3,
  parameter int FADE_RATE   = 2,
  parameter int HOLD_FRAMES = 60
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              frame_tick,
  input  logic [1:0]        over,
  input  logic              retry,
  output logic              world_rstn,
  output logic [MASK_W-1:0] mask,
  output logic [3:0]        lives,
  output logic [2:0]        state
);

  localparam logic [CNT_W-1:0]   FADE_LAST  = CNT_W'(FADE_RATE - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  state_t             state_q, state_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         cause_q, cause_d;
  logic               wrst_q, wrst_d;
  logic               retry_rise;

  edge_detect u_retry_edge (
    .clk  (clk),
    .rstn (rstn),
    .din  (retry),
    .rise (retry_rise)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_TITLE;
      lvl_q   <= '0;
      lives_q <= '0;
      cnt_q   <= '0;
      cause_q <= OVER_PLAY;
      wrst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      wrst_q  <= wrst_d;
    end
  end

  // A tick that causes a transition is not counted in the new state: counters restart at 0.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    wrst_d  = wrst_q;
    unique case (state_q)
      ST_TITLE: if (retry_rise) begin
        state_d = ST_START;
        lives_d = LIVES_INIT;
        cnt_d   = '0;
        wrst_d  = 1'b0;
      end
      ST_START: if (frame_tick) begin
        state_d = ST_FADE_IN;
        lvl_d   = '0;
        cnt_d   = '0;
        wrst_d  = 1'b1;
      end
      ST_FADE_IN: if (frame_tick) begin
        if (cnt_q >= FADE_LAST) begin
          cnt_d = '0;
          if (lvl_q != LVL_MAX) lvl_d = lvl_q + 1'b1;
          if (lvl_q >= LVL_MAX - 1'b1) state_d = ST_PLAY;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_PLAY: begin
        lvl_d = LVL_MAX;
        if (over == OVER_DIED || over == OVER_WON) begin
          cause_d = over;
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: if (frame_tick) begin
        if (cnt_q >= HOLD_LAST) begin
          state_d = ST_FADE_OUT;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_FADE_OUT: if (frame_tick) begin
        if (cnt_q >= FADE_LAST) begin
          cnt_d = '0;
          if (lvl_q != '0) lvl_d = lvl_q - 1'b1;
          if (lvl_q <= 4'd1) begin
            if (cause_q == OVER_WON) begin
              state_d = ST_WON;
            end else if (lives_q > 4'd1) begin
              lives_d = lives_q - 1'b1;
              state_d = ST_START;
              wrst_d  = 1'b0;
            end else begin
              lives_d = '0;
              state_d = ST_GAMEOVER;
            end
          end
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_GAMEOVER, ST_WON: begin
        lvl_d = '0;
        if (retry_rise) begin
          state_d = ST_TITLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_TITLE;
    endcase
  end

  assign world_rstn = wrst_q;
  assign mask       = {lvl_q, lvl_q, lvl_q};
  assign lives      = lives_q;
  assign state      = state_q;

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter LIVES, default 3, meaning lives granted per new game (1..15).
REQ-002 SHALL have parameter FADE_RATE, default 2, meaning frame ticks per fade level step (>=1).
REQ-003 SHALL have parameter HOLD_FRAMES, default 60, meaning frame ticks held after death or win before fading (>=1).
REQ-004 SHALL have port clk  in  1  system clock; the single clock, all state on its rising edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port frame_tick  in  1  one-clk pulse per game frame (a registered edge of clkdiv[17]).
REQ-007 SHALL have port over  in  2  World status: 0 playing, 1 died, 2 won, 3 reserved (treated as 0).
REQ-008 SHALL have port retry  in  1  level from Input; only rising edges count.
REQ-009 SHALL have port world_rstn  out  1  active-low reset to World, low for exactly one frame per (re)start.
REQ-010 SHALL have port mask  out  12  brightness mask {lvl,lvl,lvl}, where lvl is 4 bits.
REQ-011 SHALL have port lives  out  4  lives remaining.
REQ-012 SHALL have port state  out  3  current FSM state encoding, for debug and Output overlays.

Function
REQ-013 SHALL implement the states TITLE, START, FADE_IN, PLAY, HOLD, FADE_OUT, GAMEOVER and WON.
REQ-014 TITLE SHALL go to START on a retry rising edge, and SHALL load lives=LIVES.
REQ-015 START SHALL drive world_rstn=0 from entry until the next frame_tick, then go to FADE_IN with lvl=0.
REQ-016 FADE_IN SHALL increment lvl by 1 every FADE_RATE frame ticks, and SHALL go to PLAY on the tick that reaches lvl=15.
REQ-017 PLAY SHALL hold lvl=15, SHALL sample over every clk, and on over=1 or over=2 SHALL latch the cause and go to HOLD.
REQ-018 HOLD SHALL count HOLD_FRAMES frame ticks with the mask unchanged, then go to FADE_OUT.
REQ-019 FADE_OUT SHALL decrement lvl by 1 every FADE_RATE frame ticks; at lvl=0 it SHALL select the next state as follows:
 - cause=won: go to WON;
 - cause=died and lives>1: decrement lives, go to START;
 - cause=died and lives==1: set lives=0, go to GAMEOVER.
REQ-020 GAMEOVER and WON SHALL hold lvl=0 and SHALL go to TITLE on a retry rising edge.
REQ-021 Retry edges in START, FADE_IN, PLAY, HOLD and FADE_OUT SHALL be ignored and SHALL NOT be queued.
REQ-022 The retry edge detector SHALL use one clk of history; retry held high through reset SHALL NOT produce an edge.
REQ-023 over changes outside PLAY SHALL be ignored; over=3 in PLAY SHALL be treated as 0.
REQ-024 The frame and fade counters SHALL saturate, never wrap; lives SHALL never underflow below 0.
REQ-025 When a frame_tick coincides with a state transition, the tick SHALL be consumed by the transition only.
REQ-026 All outputs SHALL be registered; mask SHALL change only on frame_tick clk cycles.

Reset
REQ-027 Asserting rstn low SHALL asynchronously force the following, at any time including mid-fade:
 - state=TITLE, lvl=0, mask=12'h000, world_rstn=0, lives=0;
 - all counters and the latched cause cleared, and the retry history cleared to 1.
REQ-028 While in TITLE after reset, world_rstn SHALL remain 0 until START completes.

Structure
REQ-029 A shared package SHALL hold the state encoding constants, the over codes (OVER_PLAY=0, OVER_DIED=1, OVER_WON=2) and MASK_W=12.
REQ-030 The design SHALL contain one sub-module, edge_detect (rising-edge, async active-low reset), used for retry.

Verification
REQ-031 Reset, then a retry pulse, with defaults -> world_rstn low for 1 frame, then mask ramps 000, 111 ... FFF over 30 ticks, state=PLAY, lives=3.
REQ-032 In PLAY, over=1 for one clk -> 60 ticks at FFF, fade to 000 in 30 ticks, then world_rstn low for 1 frame, lives=2, fade in again.
REQ-033 Three deaths from lives=3 -> state=GAMEOVER, lives=0, mask=000; a retry edge then goes to TITLE, and a second edge gives lives=3.
REQ-034 over=2 in PLAY -> HOLD, FADE_OUT, then WON with lives unchanged; over=1 arriving during HOLD is ignored (cause stays won).
REQ-035 rstn pulsed low mid-FADE_IN at lvl=7 -> immediately mask=000, state=TITLE, world_rstn=0; with retry held high across reset, no start occurs.
REQ-036 Retry toggled during PLAY, and frame_tick coincident with the death sample -> no restart; HOLD count starts on the following tick (exactly 60 ticks).
